stb_gen: RTL and testbench

STB_GEN -- requirements
Module: stb_gen

---
 rtl/stb_gen.sv | 132 +++++++++++++
 tb/tb_stb_gen.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stb_gen.sv
// Strobe generator: measures the period of an asynchronous periodic input, then
// free-runs a one-cycle strobe on that period until re-armed by run_det_i.
module stb_gen #(
    parameter int T_CNT_WIDTH = 32
) (
    input  logic                   clk_i,
    input  logic                   arst_i,
    input  logic                   sig_i,
    input  logic                   run_det_i,
    input  logic                   oe_i,
    output logic                   stb_o,
    output logic                   rdy_o,
    output logic                   err_o,
    output logic [T_CNT_WIDTH-1:0] stb_period_o,
    output logic [1:0]             dbg_state_o
);
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_EDGE = 2'd1,
        S_MEASURE   = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    localparam logic [T_CNT_WIDTH-1:0] C_ONE = T_CNT_WIDTH'(1);
    localparam logic [T_CNT_WIDTH-1:0] C_TWO = T_CNT_WIDTH'(2);

    logic                   r_sig_s1;
    logic                   r_sig_s2;
    logic                   r_sig_d;
    logic                   r_run_q;
    logic                   r_run_d;
    state_t                 r_state;
    logic [T_CNT_WIDTH-1:0] r_cnt;
    logic [T_CNT_WIDTH-1:0] r_phase;
    logic [T_CNT_WIDTH-1:0] r_period;
    logic                   r_stb;
    logic                   r_rdy;
    logic                   r_err;

    logic                   w_sig_rise;
    logic                   w_run_rise;
    logic                   w_cnt_max;
    logic                   w_phase_hit;

    assign w_sig_rise  = r_sig_s2 & ~r_sig_d;
    assign w_run_rise  = r_run_q & ~r_run_d;
    assign w_cnt_max   = &r_cnt;
    assign w_phase_hit = (r_phase == r_period);

    // sig_i crosses domains through s1/s2; r_sig_d only serves the edge detector.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_sig_s1 <= 1'b0;
            r_sig_s2 <= 1'b0;
            r_sig_d  <= 1'b0;
            r_run_q  <= 1'b0;
            r_run_d  <= 1'b0;
        end else begin
            r_sig_s1 <= sig_i;
            r_sig_s2 <= r_sig_s1;
            r_sig_d  <= r_sig_s2;
            r_run_q  <= run_det_i;
            r_run_d  <= r_run_q;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_phase  <= '0;
            r_period <= '0;
            r_stb    <= 1'b0;
            r_rdy    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_stb <= 1'b0;
            // A fresh run_det rise re-arms from any state, abandoning any run in progress.
            if (w_run_rise) begin
                r_err   <= 1'b0;
                r_rdy   <= 1'b0;
                r_state <= S_WAIT_EDGE;
            end else begin
                case (r_state)
                    S_IDLE: ;
                    S_WAIT_EDGE: begin
                        if (w_sig_rise) begin
                            r_cnt   <= C_ONE;
                            r_state <= S_MEASURE;
                        end
                    end
                    S_MEASURE: begin
                        if (w_sig_rise) begin
                            if (r_cnt < C_TWO) begin
                                r_err   <= 1'b1;
                                r_state <= S_IDLE;
                            end else begin
                                r_period <= r_cnt;
                                r_rdy    <= 1'b1;
                                r_phase  <= C_ONE;
                                r_stb    <= oe_i;
                                r_state  <= S_RUN;
                            end
                        end else if (w_cnt_max) begin
                            r_err   <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt + C_ONE;
                        end
                    end
                    S_RUN: begin
                        // Phase keeps counting with oe_i low so re-enabled strobes stay on grid.
                        if (w_phase_hit) begin
                            r_phase <= C_ONE;
                            r_stb   <= oe_i;
                        end else begin
                            r_phase <= r_phase + C_ONE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign stb_o        = r_stb;
    assign rdy_o        = r_rdy;
    assign err_o        = r_err;
    assign stb_period_o = r_period;
    assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_stb_gen.sv
// Bench for stb_gen: cycle-aligned periodic sig_i stimulus, with the strobe grid
// predicted from the programmed period and checked cycle by cycle.
module tb_stb_gen;
    logic        clk;
    logic        arst;
    logic        sig_i;
    logic        run_det;
    logic        run_det8;
    logic        oe;
    logic        stb;
    logic        rdy;
    logic        err;
    logic [31:0] period;
    logic [1:0]  st;
    logic        stb8;
    logic        rdy8;
    logic        err8;
    logic [7:0]  period8;
    logic [1:0]  st8;

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    bit sig_en = 1'b0;
    int sig_per = 100;
    int sig_hi = 10;
    int sig_ph = 0;
    int edge_q[$];

    stb_gen #(.T_CNT_WIDTH(32)) u_dut (
        .clk_i(clk), .arst_i(arst), .sig_i(sig_i), .run_det_i(run_det), .oe_i(oe),
        .stb_o(stb), .rdy_o(rdy), .err_o(err), .stb_period_o(period), .dbg_state_o(st)
    );

    stb_gen #(.T_CNT_WIDTH(8)) u_dut8 (
        .clk_i(clk), .arst_i(arst), .sig_i(sig_i), .run_det_i(run_det8), .oe_i(oe),
        .stb_o(stb8), .rdy_o(rdy8), .err_o(err8), .stb_period_o(period8), .dbg_state_o(st8)
    );

    initial begin
        clk = 1'b0;
        forever #4 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Periodic sig_i: high for sig_hi of every sig_per cycles; each rising edge is logged.
    initial begin
        sig_i = 1'b0;
        forever begin
            @(negedge clk);
            if (sig_en) begin
                sig_i = (sig_ph < sig_hi);
                if (sig_ph == 0) edge_q.push_back(cyc);
                sig_ph = (sig_ph + 1 == sig_per) ? 0 : sig_ph + 1;
            end else begin
                sig_i  = 1'b0;
                sig_ph = 0;
            end
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_rdy(input int budget, output int ok, output int at, output int stray);
        ok = 0;
        at = -1;
        stray = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (rdy) begin
                ok = 1;
                at = cyc;
                break;
            end
            if (stb) stray++;
        end
    endtask

    // Expected strobe at cycle c: c lies on the grid g0 + k*p and oe was high at that edge.
    task automatic check_run(input int ncyc, input int g0, input int p, input int off_a,
                             input int off_b, output int bad, output int n_obs, output int n_exp);
        logic exp_stb;
        logic oe_prev;
        bad = 0;
        n_obs = 0;
        n_exp = 0;
        for (int k = 0; k < ncyc; k++) begin
            oe_prev = oe;
            @(negedge clk);
            exp_stb = (((cyc - g0) % p) == 0) && oe_prev;
            if (stb) n_obs++;
            if (exp_stb) n_exp++;
            if (stb !== exp_stb || rdy !== 1'b1) begin
                if (bad == 0) $display("first grid deviation at cycle %0d (stb=%0b rdy=%0b)", cyc, stb, rdy);
                bad++;
            end
            if (k + 1 == off_a) oe = 1'b0;
            if (k + 1 == off_b) oe = 1'b1;
        end
    endtask

    task automatic measure(input int p, output int g0);
        int ok;
        int stray;
        int e2;
        sig_per = p;
        sig_hi = p / 4 + 1;
        edge_q.delete();
        sig_en = 1'b1;
        wait_rdy(2 * p + 20, ok, g0, stray);
        chk("rdy_rise", ok, 1);
        chk("no_stb_while_measuring", stray, 0);
        e2 = (edge_q.size() >= 2) ? edge_q[1] : -100;
        chk("rdy_latency", int'((g0 - e2) >= 1 && (g0 - e2) <= 4), 1);
        chk("period", int'(period), p);
        chk("first_stb_on_entry", int'(stb), 1);
        chk("err_low_in_run", int'(err), 0);
    endtask

    initial begin
        int g0;
        int bad;
        int nobs;
        int nexp;
        int t_err;
        int e1;
        int p;
        int prev_p;
        int cnt;
        int periods[4];

        arst = 1'b1;
        run_det = 1'b0;
        run_det8 = 1'b0;
        oe = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_stb", int'(stb), 0);
        chk("rst_rdy", int'(rdy), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_period", int'(period), 0);
        chk("rst_err8", int'(err8), 0);
        chk("rst_rdy8", int'(rdy8), 0);
        arst = 1'b0;

        // No run_det rise yet: sig_i activity must not start anything.
        sig_per = 50;
        sig_hi = 10;
        sig_en = 1'b1;
        cnt = 0;
        repeat (150) begin
            @(negedge clk);
            if (rdy || stb || err) cnt++;
        end
        chk("idle_after_reset", cnt, 0);
        sig_en = 1'b0;
        repeat (5) @(negedge clk);

        // 8-bit instance: one edge then silence must time out at an all-ones count.
        run_det8 = 1'b1;
        repeat (2) @(negedge clk);
        run_det8 = 1'b0;
        repeat (4) @(negedge clk);
        edge_q.delete();
        sig_per = 1000;
        sig_hi = 3;
        sig_en = 1'b1;
        t_err = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (err8) begin
                t_err = cyc;
                break;
            end
        end
        sig_en = 1'b0;
        e1 = (edge_q.size() > 0) ? edge_q[0] : -1000;
        chk("timeout_err8", int'(err8), 1);
        chk("timeout_delay", int'((t_err - e1) >= 255 && (t_err - e1) <= 260), 1);
        chk("timeout_rdy8", int'(rdy8), 0);
        @(negedge clk);
        run_det8 = 1'b1;
        repeat (3) @(negedge clk);
        chk("err8_cleared_by_rearm", int'(err8), 0);
        run_det8 = 1'b0;

        periods[0] = 1250;
        for (int i = 1; i < 4; i++) periods[i] = $urandom_range(300, 20);

        for (int i = 0; i < 4; i++) begin
            p = periods[i];
            sig_en = 1'b0;
            oe = 1'b1;
            @(negedge clk);
            run_det = 1'b1;
            repeat (2) @(negedge clk);
            if (i > 0) chk("rdy_drop_on_rearm", int'(rdy), 0);
            cnt = 0;
            repeat (2) begin
                @(negedge clk);
                if (stb) cnt++;
            end
            chk("no_stb_after_rearm", cnt, 0);
            if (i != 2) run_det = 1'b0;
            measure(p, g0);

            check_run(3 * p, g0, p, -1, -1, bad, nobs, nexp);
            chk("grid_oe_on", bad, 0);
            chk("count_oe_on", nobs, nexp);

            // sig_i stops entirely and oe_i drops for three periods; the grid must hold.
            sig_en = 1'b0;
            check_run(7 * p, g0, p, p + p / 2, 4 * p + p / 2, bad, nobs, nexp);
            chk("grid_oe_gated", bad, 0);
            chk("count_oe_gated", nobs, nexp);
            run_det = 1'b0;
        end

        // Asynchronous reset in the middle of RUN, then a different period.
        @(negedge clk);
        arst = 1'b1;
        #1;
        chk("midrun_rst_stb", int'(stb), 0);
        chk("midrun_rst_rdy", int'(rdy), 0);
        chk("midrun_rst_err", int'(err), 0);
        chk("midrun_rst_period", int'(period), 0);
        repeat (3) @(negedge clk);
        arst = 1'b0;
        sig_per = 40;
        sig_hi = 8;
        sig_en = 1'b1;
        cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (rdy || stb) cnt++;
        end
        chk("idle_after_midrun_rst", cnt, 0);
        sig_en = 1'b0;
        prev_p = periods[3];
        p = $urandom_range(300, 20);
        if (p == prev_p) p = p + 7;
        @(negedge clk);
        run_det = 1'b1;
        repeat (3) @(negedge clk);
        run_det = 1'b0;
        measure(p, g0);
        check_run(4 * p, g0, p, -1, -1, bad, nobs, nexp);
        chk("grid_after_rst", bad, 0);
        chk("count_after_rst", nobs, nexp);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
